// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: steps one vector ALU instruction through a shared scalar ALU,
// one lane per pass, holding each lane's operands for the op's latency and capturing
// the ALU result into that lane of vec_result.
// Optional feature macro: SKIP_DIV_ZERO_EN. When defined, DIV lanes with a zero divisor
// are not issued; they take one cycle, write all-ones and set the sticky div_zero output.
module vector_alu_sequencer #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 4,
    localparam int unsigned LaneW  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2:0]                alu_ctrl,
    input  logic [LANES*DATA_W-1:0]   vec_a,
    input  logic [LANES*DATA_W-1:0]   vec_b,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [2:0]                alu_ctrl_o,
    output logic                      alu_valid,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      busy,
    output logic                      done,
    output logic [LANES*DATA_W-1:0]   vec_result,
    output logic                      bad_op,
    output logic [LaneW-1:0]          lane_idx
`ifdef SKIP_DIV_ZERO_EN
    ,
    output logic                      div_zero
`endif
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    // Counter only needs to reach L-1 within an element.
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b011;
    localparam logic [2:0] OpDiv = 3'b100;
    localparam logic [2:0] OpCmp = 3'b101;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e                    state_q, state_d;
    logic [LANES*DATA_W-1:0]   vec_a_q, vec_a_d;
    logic [LANES*DATA_W-1:0]   vec_b_q, vec_b_d;
    logic [2:0]                op_q, op_d;
    logic [LaneW-1:0]          lane_q, lane_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [LANES*DATA_W-1:0]   vec_result_q, vec_result_d;
    logic                      bad_op_q, bad_op_d;
`ifdef SKIP_DIV_ZERO_EN
    logic                      div_zero_q, div_zero_d;
`endif

    logic                      op_supported;
    logic [CntW-1:0]           lat_m1;
    logic [DATA_W-1:0]         lane_a;
    logic [DATA_W-1:0]         lane_b;
    logic                      skip_lane;
    logic                      elem_last;

    // Decode whether the incoming op code has a datapath in the scalar ALU.
    always_comb begin
        op_supported = 1'b0;
        case (alu_ctrl)
            OpAdd, OpSub, OpMul, OpDiv, OpCmp: op_supported = 1'b1;
            default:                           op_supported = 1'b0;
        endcase
    end

    // Current lane operands, per-op latency and end-of-element detection.
    always_comb begin
        lane_a = vec_a_q[lane_q*DATA_W +: DATA_W];
        lane_b = vec_b_q[lane_q*DATA_W +: DATA_W];
        lat_m1 = '0;
        case (op_q)
            OpMul:   lat_m1 = CntW'(MUL_LAT - 1);
            OpDiv:   lat_m1 = CntW'(DIV_LAT - 1);
            default: lat_m1 = '0;
        endcase
        skip_lane = 1'b0;
`ifdef SKIP_DIV_ZERO_EN
        skip_lane = (op_q == OpDiv) && (lane_b == '0);
`endif
        elem_last = skip_lane || (cnt_q == lat_m1);
    end

    // Next-state logic for the IDLE -> EXEC -> DONE sequence.
    always_comb begin
        state_d      = state_q;
        vec_a_d      = vec_a_q;
        vec_b_d      = vec_b_q;
        op_d         = op_q;
        lane_d       = lane_q;
        cnt_d        = cnt_q;
        vec_result_d = vec_result_q;
        bad_op_d     = bad_op_q;
`ifdef SKIP_DIV_ZERO_EN
        div_zero_d   = div_zero_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    vec_a_d      = vec_a;
                    vec_b_d      = vec_b;
                    op_d         = alu_ctrl;
                    vec_result_d = '0;
                    lane_d       = '0;
                    cnt_d        = '0;
`ifdef SKIP_DIV_ZERO_EN
                    div_zero_d   = 1'b0;
`endif
                    if (op_supported) begin
                        state_d = StExec;
                    end else begin
                        state_d  = StDone;
                        bad_op_d = 1'b1;
                    end
                end
            end
            StExec: begin
                if (elem_last) begin
                    vec_result_d[lane_q*DATA_W +: DATA_W] = skip_lane ? '1 : alu_result;
                    cnt_d = '0;
`ifdef SKIP_DIV_ZERO_EN
                    if (skip_lane) begin
                        div_zero_d = 1'b1;
                    end
`endif
                    if (lane_q == LaneW'(LANES - 1)) begin
                        state_d = StDone;
                        lane_d  = '0;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d  = StIdle;
                bad_op_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            vec_a_q      <= '0;
            vec_b_q      <= '0;
            op_q         <= '0;
            lane_q       <= '0;
            cnt_q        <= '0;
            vec_result_q <= '0;
            bad_op_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_a_q      <= vec_a_d;
            vec_b_q      <= vec_b_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            vec_result_q <= vec_result_d;
            bad_op_q     <= bad_op_d;
        end
    end

`ifdef SKIP_DIV_ZERO_EN
    // Sticky zero-divisor flag, cleared by reset or the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_zero_q <= 1'b0;
        end else begin
            div_zero_q <= div_zero_d;
        end
    end

    assign div_zero = div_zero_q;
`endif

    // Outputs decoded from state; ALU-facing buses are zero whenever nothing is issued.
    always_comb begin
        alu_valid  = (state_q == StExec) && !skip_lane;
        alu_a      = alu_valid ? lane_a : '0;
        alu_b      = alu_valid ? lane_b : '0;
        alu_ctrl_o = alu_valid ? op_q : 3'b000;
        busy       = (state_q == StExec);
        done       = (state_q == StDone);
        vec_result = vec_result_q;
        bad_op     = bad_op_q;
        lane_idx   = lane_q;
    end

endmodule
